// File: rtl/dmem_ctrl_if.sv
// Data-bus port of the memory-stage load/store controller.
// master = controller side, slave = memory/bus consumer side.
interface dmem_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [3:0]        bus_be;
  logic              bus_gnt;
  logic              bus_rvalid;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    output bus_gnt, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Memory-stage load/store sequencer: sizing, alignment faults, lane steering,
// load extraction/extension and a bus timeout, one response per accepted request.
module dmem_ctrl #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall_out,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              misaligned,
  dmem_ctrl_if.master       bus
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              legal;
  logic              timeout;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic [DATA_W-1:0] load_ext;
  logic [DATA_W-1:0] st_data;
  logic [3:0]        st_be;

  always_comb begin
    legal = 1'b0;
    case (req_size)
      2'b00:   legal = 1'b1;
      2'b01:   legal = ~req_addr[0];
      2'b10:   legal = (req_addr[1:0] == 2'b00);
      default: legal = 1'b0;
    endcase
  end

  // Store data is replicated across lanes so the slave can pick it with be alone.
  always_comb begin
    st_data = req_wdata;
    st_be   = 4'b1111;
    case (req_size)
      2'b00: begin
        st_data = {4{req_wdata[7:0]}};
        st_be   = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        st_data = {2{req_wdata[15:0]}};
        st_be   = 4'b0011 << req_addr[1:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    lane_b = bus.bus_rdata[7:0];
    case (addr_q[1:0])
      2'b00: lane_b = bus.bus_rdata[7:0];
      2'b01: lane_b = bus.bus_rdata[15:8];
      2'b10: lane_b = bus.bus_rdata[23:16];
      2'b11: lane_b = bus.bus_rdata[31:24];
    endcase
    lane_h   = addr_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
    load_ext = bus.bus_rdata;
    case (size_q)
      2'b00:   load_ext = uns_q ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
      2'b01:   load_ext = uns_q ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: load_ext = bus.bus_rdata;
    endcase
  end

  assign timeout = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    we_d          = we_q;
    size_d        = size_q;
    uns_d         = uns_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    be_d          = be_q;
    rdata_d       = rdata_q;
    err_d         = err_q;
    stall_out     = 1'b0;
    resp_valid    = 1'b0;
    resp_rdata    = '0;
    resp_err      = 1'b0;
    misaligned    = 1'b0;
    bus.bus_req   = 1'b0;
    bus.bus_we    = 1'b0;
    bus.bus_addr  = '0;
    bus.bus_wdata = '0;
    bus.bus_be    = 4'b0000;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (legal) begin
            stall_out = 1'b1;
            we_d      = req_we;
            size_d    = req_size;
            uns_d     = req_unsigned;
            addr_d    = req_addr;
            wdata_d   = st_data;
            be_d      = st_be;
            rdata_d   = '0;
            err_d     = 1'b0;
            cnt_d     = '0;
            state_d   = ISSUE;
          end else begin
            misaligned = 1'b1;
          end
        end
      end
      ISSUE: begin
        stall_out     = 1'b1;
        bus.bus_req   = 1'b1;
        bus.bus_we    = we_q;
        bus.bus_addr  = {addr_q[ADDR_W-1:2], 2'b00};
        bus.bus_wdata = wdata_q;
        bus.bus_be    = be_q;
        cnt_d         = cnt_q + 1'b1;
        // Timeout wins over a same-cycle grant; rvalid is never looked at here.
        if (timeout) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = DONE;
        end else if (bus.bus_gnt) begin
          state_d = we_q ? DONE : WAIT;
        end
      end
      WAIT: begin
        stall_out = 1'b1;
        cnt_d     = cnt_q + 1'b1;
        if (timeout) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = DONE;
        end else if (bus.bus_rvalid) begin
          rdata_d = load_ext;
          state_d = DONE;
        end
      end
      DONE: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        resp_err   = err_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= 4'b0000;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule
